// File: rtl/sram_responder.sv
// sram_responder: dual-port word SRAM model (instruction read port, byte-write data port)
// with one-cycle read latency, range checking and access counters.
module sram_responder #(
  parameter int          DEPTH_W   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  logic [31:0] mem [2**DEPTH_W];
  logic [31:0] i_off, d_off;
  logic [DEPTH_W-1:0] i_idx, d_idx;
  logic i_ok, d_ok, i_rd, d_rd, d_wr, unused;
  always_comb begin
    i_off = inst_sram_addr - BASE_ADDR;
    d_off = data_sram_addr - BASE_ADDR;
    i_idx = i_off[DEPTH_W+1:2];
    d_idx = d_off[DEPTH_W+1:2];
    i_ok  = (i_off >> (DEPTH_W + 2)) == 32'd0;
    d_ok  = (d_off >> (DEPTH_W + 2)) == 32'd0;
    i_rd  = inst_sram_en && i_ok;
    d_rd  = data_sram_en && d_ok && data_sram_wen == 4'd0;
    d_wr  = data_sram_en && d_ok && data_sram_wen != 4'd0;
  end
  assign unused = ^{inst_sram_wen, inst_sram_wdata, i_off[1:0], d_off[1:0]};
  // Memory is deliberately outside the reset domain; rst only suppresses writes.
  always_ff @(posedge clk)
    if (!rst && d_wr)
      for (int b = 0; b < 4; b++)
        if (data_sram_wen[b]) mem[d_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
      addr_err        <= 1'b0;
      rd_cnt          <= 32'd0;
      wr_cnt          <= 32'd0;
    end else begin
      if (inst_sram_en) inst_sram_rdata <= i_ok ? mem[i_idx] : 32'd0;
      if (data_sram_en) data_sram_rdata <= d_ok ? mem[d_idx] : 32'd0;
      if ((inst_sram_en && !i_ok) || (data_sram_en && !d_ok)) addr_err <= 1'b1;
      rd_cnt <= rd_cnt + 32'(i_rd) + 32'(d_rd);
      wr_cnt <= wr_cnt + 32'(d_wr);
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for sram_responder with a behavioural memory model.
module tb_sram_responder;
  localparam int          DW   = 12;
  localparam logic [31:0] BASE = 32'h1FC0_0000;
  localparam logic [31:0] SPAN = 32'd4 << DW;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_sram_en = 1'b0, data_sram_en = 1'b0;
  logic [3:0] inst_sram_wen = 4'd0, data_sram_wen = 4'd0;
  logic [31:0] inst_sram_addr = 32'd0, inst_sram_wdata = 32'd0;
  logic [31:0] data_sram_addr = 32'd0, data_sram_wdata = 32'd0;
  logic [31:0] inst_sram_rdata, data_sram_rdata, rd_cnt, wr_cnt;
  logic addr_err;
  typedef struct {
    logic [31:0] i, d, rc, wc;
    logic e;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic [31:0] mdl [1<<DW];
  int n_chk = 0, n_fail = 0;
  sram_responder #(.DEPTH_W(DW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .addr_err(addr_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check({tag, ":inst"}, inst_sram_rdata, x.i);
    check({tag, ":data"}, data_sram_rdata, x.d);
    check({tag, ":err"}, 32'(addr_err), 32'(x.e));
    check({tag, ":rd_cnt"}, rd_cnt, x.rc);
    check({tag, ":wr_cnt"}, wr_cnt, x.wc);
  endtask
  // Called at posedge+1: drive one cycle, predict, clock it, compare.
  task automatic step(input string tag, input logic ie, input logic [31:0] ia,
                      input logic de, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dd);
    exp_t x;
    logic [31:0] io, dof;
    int ii, di;
    inst_sram_en = ie; inst_sram_addr = ia;
    inst_sram_wen = 4'($urandom); inst_sram_wdata = $urandom;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    io = ia - BASE; dof = da - BASE;
    ii = int'(io[DW+1:2]); di = int'(dof[DW+1:2]);
    x = cur;
    if (!rst) begin
      if (ie) begin
        if (io < SPAN) begin x.i = mdl[ii]; x.rc++; end
        else begin x.i = 32'd0; x.e = 1'b1; end
      end
      if (de) begin
        if (dof < SPAN) begin
          x.d = mdl[di];
          if (dw == 4'd0) x.rc++;
          else begin
            x.wc++;
            for (int b = 0; b < 4; b++) if (dw[b]) mdl[di][8*b +: 8] = dd[8*b +: 8];
          end
        end else begin x.d = 32'd0; x.e = 1'b1; end
      end
    end
    sb.push_back(x);
    cur = x;
    @(posedge clk); #1;
    check_all(tag);
  endtask
  initial begin
    cur = '{i: 32'd0, d: 32'd0, rc: 32'd0, wc: 32'd0, e: 1'b0};
    #2;
    check("por_inst", inst_sram_rdata, 32'd0);
    check("por_data", data_sram_rdata, 32'd0);
    check("por_err", 32'(addr_err), 32'd0);
    check("por_rd", rd_cnt, 32'd0);
    check("por_wr", wr_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("wr10", 0, BASE, 1, 4'hF, BASE + 32'h10, 32'h1234_5678);
    step("rd10", 0, BASE, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("rd10_val", data_sram_rdata, 32'h1234_5678);
    check("rd10_cnt", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1, 16'd1});
    step("wrb1", 0, BASE, 1, 4'b0010, BASE + 32'h10, 32'hAAAA_BBCC);
    step("rdb1", 0, BASE, 1, 4'h0, BASE + 32'h12, 32'h0);
    check("rdb1_val", data_sram_rdata, 32'h1234_BB78);
    step("coll", 1, BASE + 32'h10, 1, 4'hF, BASE + 32'h10, 32'h0);
    check("coll_inst", inst_sram_rdata, 32'h1234_BB78);
    step("rd0", 0, BASE, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("rd0_val", data_sram_rdata, 32'h0);
    step("wr10b", 0, BASE, 1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D);
    for (int w = 0; w < 8; w++)
      if (w != 4) step("init", 0, BASE, 1, 4'hF, BASE + 32'(4 * w), $urandom);
    step("wrlast", 0, BASE, 1, 4'hF, BASE + SPAN - 32'd4, 32'h5A5A_A5A5);
    step("both", 1, BASE + SPAN - 32'd1, 1, 4'h0, BASE + 32'h13, 32'h0);
    step("oor_wr", 0, BASE, 1, 4'hF, BASE + SPAN + 32'h10, 32'hDEAD_BEEF);
    step("oor_rd", 1, BASE + 32'h10, 1, 4'h0, BASE + SPAN, 32'h0);
    check("oor_data", data_sram_rdata, 32'h0);
    check("oor_err", 32'(addr_err), 32'd1);
    step("oor_inst", 1, BASE - 32'd4, 0, 4'h0, BASE, 32'h0);
    step("after_oor", 1, BASE + 32'h10, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("alias_safe", data_sram_rdata, 32'hCAFE_F00D);
    step("hold_rd", 1, BASE + SPAN - 32'd4, 0, 4'h0, BASE, 32'h0);
    for (int k = 0; k < 3; k++) step("hold", 0, BASE + 32'h10, 0, 4'h0, BASE, 32'h0);
    check("hold_val", inst_sram_rdata, 32'h5A5A_A5A5);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ia, da;
      ia = ($urandom_range(0, 7) == 0) ? BASE + SPAN + 32'($urandom_range(0, 255))
                                       : BASE + 32'($urandom_range(0, 31));
      da = ($urandom_range(0, 7) == 0) ? BASE - 32'($urandom_range(1, 64))
                                       : BASE + 32'($urandom_range(0, 31));
      step("rand", 1'($urandom), ia, 1'($urandom), 4'($urandom), da, $urandom);
    end
    step("pre_rst", 0, BASE, 1, 4'hF, BASE + 32'h10, 32'h0BAD_C0DE);
    #2 rst = 1'b1;
    cur = '{i: 32'd0, d: 32'd0, rc: 32'd0, wc: 32'd0, e: 1'b0};
    #1;
    check("arst_inst", inst_sram_rdata, 32'd0);
    check("arst_data", data_sram_rdata, 32'd0);
    check("arst_err", 32'(addr_err), 32'd0);
    check("arst_rd", rd_cnt, 32'd0);
    check("arst_wr", wr_cnt, 32'd0);
    @(posedge clk); #1;
    step("in_rst", 1, BASE + 32'h10, 1, 4'hF, BASE + 32'h10, 32'hFFFF_FFFF);
    rst = 1'b0;
    step("post_rst", 1, BASE + 32'h10, 1, 4'h0, BASE + 32'h10, 32'h0);
    check("post_rst_val", data_sram_rdata, 32'h0BAD_C0DE);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_W, default 12, giving a memory of 2^DEPTH_W 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0 for both ports.
REQ-003 SHALL have port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port inst_sram_en, input, 1: instruction-port access request.
REQ-006 SHALL have port inst_sram_wen, input, 4: instruction-port byte write enables; accepted and ignored.
REQ-007 SHALL have port inst_sram_addr, input, 32: instruction byte address.
REQ-008 SHALL have port inst_sram_wdata, input, 32: accepted and ignored.
REQ-009 SHALL have port inst_sram_rdata, output, 32: instruction read data.
REQ-010 SHALL have port data_sram_en, input, 1: data-port access request.
REQ-011 SHALL have port data_sram_wen, input, 4: data-port byte write enables; bit i writes byte lane i, bits [8i+7:8i].
REQ-012 SHALL have port data_sram_addr, input, 32: data byte address.
REQ-013 SHALL have port data_sram_wdata, input, 32: write data.
REQ-014 SHALL have port data_sram_rdata, output, 32: data read data.
REQ-015 SHALL have port addr_err, output, 1: sticky out-of-range access flag.
REQ-016 SHALL have port rd_cnt, output, 32: count of accepted reads on both ports.
REQ-017 SHALL have port wr_cnt, output, 32: count of accepted data writes.

Function
REQ-018 SHALL compute, per port, the offset as addr minus BASE_ADDR (32-bit, wrapping) and the word index as offset[DEPTH_W+1:2]; offset[1:0] SHALL be ignored.
REQ-019 SHALL treat an access as in range only when offset[31:DEPTH_W+2] is zero.
REQ-020 SHALL, for an in-range access with en=1 and wen=0, drive the addressed word on rdata exactly one cycle later.
REQ-021 SHALL, for an in-range data access with en=1 and wen!=0, write only the enabled byte lanes at the clock edge; data_sram_rdata SHALL show the pre-write word on the next cycle (read-before-write).
REQ-022 SHALL hold each rdata register at its previous value in any cycle where that port's en=0.
REQ-023 SHALL, for an out-of-range access with en=1, perform no write, load 32'h0 into that port's rdata register, and set addr_err on the next cycle.
REQ-024 SHALL, when both ports address the same word in one cycle and the data port writes, return the pre-write word on inst_sram_rdata.
REQ-025 SHALL clear addr_err only on reset.
REQ-026 SHALL increment rd_cnt by 0, 1 or 2 each cycle, counting in-range en=1 read accesses on the instruction port plus in-range en=1, wen=0 accesses on the data port.
REQ-027 SHALL increment wr_cnt by 1 for each in-range data access with en=1 and wen!=0.
REQ-028 SHALL let rd_cnt and wr_cnt wrap modulo 2^32 without any flag.
REQ-029 SHALL have no back-pressure: every en=1 request is accepted in the cycle it is presented.

Reset
REQ-030 SHALL, while rst=1, force inst_sram_rdata, data_sram_rdata, rd_cnt and wr_cnt to 0 and addr_err to 0, independent of clk.
REQ-031 SHALL leave memory contents unchanged by reset.
REQ-032 SHALL perform no write or count in any cycle where rst=1, including a reset asserted in the middle of a sequence of accesses.

Verification
REQ-033 SHALL pass: data write addr=BASE+0x10, wen=4'hF, wdata=32'h1234_5678; the next cycle a data read of the same address -> data_sram_rdata=32'h1234_5678 one cycle later; wr_cnt=1, rd_cnt=1.
REQ-034 SHALL pass: after REQ-033, a write with wen=4'b0010 and wdata=32'hAAAA_BBCC -> a following read returns 32'h1234_BB78.
REQ-035 SHALL pass: in one cycle, an inst read of BASE+0x10 and a data write to BASE+0x10 with wdata=0 -> inst_sram_rdata=32'h1234_BB78; the next data read returns 0.
REQ-036 SHALL pass: a data read at BASE+(4<<DEPTH_W) -> data_sram_rdata=0 and addr_err=1 the next cycle, wr_cnt and rd_cnt unchanged; addr_err stays 1 after further legal accesses.
REQ-037 SHALL pass: an inst read, then 3 cycles with inst_sram_en=0 -> inst_sram_rdata holds its value.
REQ-038 SHALL pass: rst pulsed asynchronously mid-stream -> outputs are 0 immediately; a later read of BASE+0x10 still returns the stored word.
